// File: rtl/seq_det_pkg.sv
// seq_det_pkg
// Shared types and default constants for the serial pattern detector.
//   state_t     : detector FSM states (IDLE = no pattern loaded, ARMED)
//   N_DEF       : default pattern length in bits (legal 2..16)
//   OVERLAP_DEF : default overlap mode (1 = overlapping matches allowed)
//   CNT_W_DEF   : default width of the optional saturating match counter
package seq_det_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    localparam int unsigned N_DEF       = 4;
    localparam int unsigned OVERLAP_DEF = 1;
    localparam int unsigned CNT_W_DEF   = 8;

    // Width needed to hold a fill count in the range 0..n.
    function automatic int unsigned fill_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_det_satcnt.sv
// seq_det_satcnt
// Saturating up-counter used to count detected matches.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high; clears the count
//   inc   : increment request this cycle
//   cnt   : current count, sticks at 2^W-1
module seq_det_satcnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/seq_det_n.sv
// seq_det_n
// Serial pattern detector: compares the last N valid stream bits against a
// loadable N-bit pattern and emits a one-cycle registered pulse on a match.
// Optional feature macro: SEQ_DET_COUNT_EN adds the match_cnt port and a
// saturating match counter.
// Parameters:
//   N       : pattern length (2..16)
//   OVERLAP : 1 keeps shift history after a match, 0 restarts detection
//   CNT_W   : match counter width
// Ports:
//   clk       : rising-edge clock
//   reset     : synchronous, active-high reset (priority over everything)
//   pat_load  : capture pat_in, clear history, enter/stay ARMED
//   pat_in    : pattern, pat_in[N-1] is the first bit in time
//   en        : din is valid this cycle
//   din       : serial stream bit
//   armed     : pattern loaded
//   match     : one-cycle pulse, one clock after the completing bit
//   match_cnt : saturating match count (SEQ_DET_COUNT_EN only)
module seq_det_n
    import seq_det_pkg::*;
#(
    parameter int unsigned N       = N_DEF,
    parameter int unsigned OVERLAP = OVERLAP_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pat_load,
    input  logic [N-1:0]     pat_in,
    input  logic             en,
    input  logic             din,
    output logic             armed,
`ifdef SEQ_DET_COUNT_EN
    output logic             match,
    output logic [CNT_W-1:0] match_cnt
`else
    output logic             match
`endif
);

    localparam int unsigned FW = fill_width(N);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [N-1:0]  r_pat;
    logic [N-1:0]  w_pat_nxt;
    logic [N-1:0]  r_sr;
    logic [N-1:0]  w_sr_nxt;
    logic [FW-1:0] r_fill;
    logic [FW-1:0] w_fill_nxt;
    logic          r_match;

    logic [N-1:0]  w_sr_shift;
    logic [FW-1:0] w_fill_inc;
    logic          w_hit;

    // Candidate history after accepting din; the match test looks at these
    // updated values, not the registered ones.
    assign w_sr_shift = {r_sr[N-2:0], din};
    assign w_fill_inc = (r_fill == FW'(N)) ? r_fill : r_fill + 1'b1;

    // pat_load wins over a same-cycle stream bit, so it suppresses the hit.
    assign w_hit = (r_state == ARMED) && en && !pat_load &&
                   (w_sr_shift == r_pat) && (w_fill_inc == FW'(N));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_pat   <= '0;
            r_sr    <= '0;
            r_fill  <= '0;
            r_match <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pat   <= w_pat_nxt;
            r_sr    <= w_sr_nxt;
            r_fill  <= w_fill_nxt;
            r_match <= w_hit;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pat_nxt   = r_pat;
        w_sr_nxt    = r_sr;
        w_fill_nxt  = r_fill;

        if (pat_load) begin
            w_state_nxt = ARMED;
            w_pat_nxt   = pat_in;
            w_sr_nxt    = '0;
            w_fill_nxt  = '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    // Stream is ignored until a pattern is loaded.
                end
                ARMED: begin
                    if (en) begin
                        if (w_hit && (OVERLAP == 0)) begin
                            w_sr_nxt   = '0;
                            w_fill_nxt = '0;
                        end else begin
                            w_sr_nxt   = w_sr_shift;
                            w_fill_nxt = w_fill_inc;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    assign armed = (r_state == ARMED);
    assign match = r_match;

`ifdef SEQ_DET_COUNT_EN
    // Counting w_hit lands the increment on the same edge match rises.
    seq_det_satcnt #(
        .W(CNT_W)
    ) u_satcnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_hit),
        .cnt   (match_cnt)
    );
`endif

endmodule

// File: tb/tb_seq_det_n.sv
module tb_seq_det_n;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       pl;
    logic [3:0] pi;
    logic       en;
    logic       din;

    logic       arm0, mt0, arm1, mt1;
`ifdef SEQ_DET_COUNT_EN
    logic [7:0] cnt0;
    logic [1:0] cnt1;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Instance 0: overlapping, 8-bit counter.
    seq_det_n #(.N(4), .OVERLAP(1), .CNT_W(8)) u_ov (
        .clk      (clk),
        .reset    (rst),
        .pat_load (pl),
        .pat_in   (pi),
        .en       (en),
        .din      (din),
        .armed    (arm0),
`ifdef SEQ_DET_COUNT_EN
        .match    (mt0),
        .match_cnt(cnt0)
`else
        .match    (mt0)
`endif
    );

    // Instance 1: non-overlapping, 2-bit counter.
    seq_det_n #(.N(4), .OVERLAP(0), .CNT_W(2)) u_no (
        .clk      (clk),
        .reset    (rst),
        .pat_load (pl),
        .pat_in   (pi),
        .en       (en),
        .din      (din),
        .armed    (arm1),
`ifdef SEQ_DET_COUNT_EN
        .match    (mt1),
        .match_cnt(cnt1)
`else
        .match    (mt1)
`endif
    );

    // Reference model: a pattern, an armed flag, and for each instance the
    // list of valid bits seen since the last clear (oldest first).
    bit         m_arm;
    logic [3:0] m_pat;
    bit         h0[$];
    bit         h1[$];
    bit         m_mt0, m_mt1;
    int         m_cnt0, m_cnt1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // True when the last N recorded bits spell the pattern, first bit = MSB.
    function automatic bit tail_matches(input bit q[$], input logic [3:0] p);
        if (q.size() != N) return 1'b0;
        for (int i = 0; i < N; i++)
            if (q[i] != p[N-1-i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_arm = 0; m_pat = '0; h0.delete(); h1.delete();
            m_mt0 = 0; m_mt1 = 0; m_cnt0 = 0; m_cnt1 = 0;
        end else if (pl) begin
            m_arm = 1; m_pat = pi; h0.delete(); h1.delete();
            m_mt0 = 0; m_mt1 = 0;
        end else begin
            m_mt0 = 0; m_mt1 = 0;
            if (m_arm && en) begin
                h0.push_back(din);
                if (h0.size() > N) void'(h0.pop_front());
                if (tail_matches(h0, m_pat)) begin
                    m_mt0 = 1;
                    if (m_cnt0 < 255) m_cnt0++;
                end
                h1.push_back(din);
                if (h1.size() > N) void'(h1.pop_front());
                if (tail_matches(h1, m_pat)) begin
                    m_mt1 = 1;
                    if (m_cnt1 < 3) m_cnt1++;
                    h1.delete();
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit l, input logic [3:0] p, input bit e, input bit d);
        rst = r; pl = l; pi = p; en = e; din = d;
        @(posedge clk);
        model_edge();
        #1;
        chk("armed_ov", {31'b0, arm0}, {31'b0, m_arm});
        chk("match_ov", {31'b0, mt0},  {31'b0, m_mt0});
        chk("armed_no", {31'b0, arm1}, {31'b0, m_arm});
        chk("match_no", {31'b0, mt1},  {31'b0, m_mt1});
`ifdef SEQ_DET_COUNT_EN
        chk("cnt_ov", {24'b0, cnt0}, m_cnt0);
        chk("cnt_no", {30'b0, cnt1}, m_cnt1);
`endif
    endtask

    // Send len bits MSB first; optionally insert en=0 cycles between bits.
    task automatic send(input logic [15:0] b, input int len, input bit gaps);
        for (int i = len - 1; i >= 0; i--) begin
            step(0, 0, 4'h0, 1, b[i]);
            if (gaps && i > 0) begin
                step(0, 0, 4'h0, 0, 1'($urandom));
                step(0, 0, 4'h0, 0, 1'($urandom));
            end
        end
    endtask

    initial begin
        step(1, 0, 4'h0, 0, 0);
        step(1, 0, 4'h0, 0, 0);

        // Stream without any pattern loaded.
        send(16'b1011, 4, 0);

        // Overlapping vs restarting detection on 1011011.
        step(0, 1, 4'b1011, 0, 0);
        send(16'b1011011, 7, 0);
        step(0, 0, 4'h0, 0, 0);

        // Idle cycles inside the pattern.
        step(0, 1, 4'b1011, 0, 0);
        send(16'b1011, 4, 1);
        step(0, 0, 4'h0, 0, 0);

        // Reload on the completing bit discards it; a fresh pattern matches.
        step(0, 1, 4'b1011, 0, 0);
        send(16'b101, 3, 0);
        step(0, 1, 4'b1011, 1, 1);
        send(16'b1011, 4, 0);

        // All-ones pattern: consecutive pulses, counter saturation.
        step(0, 1, 4'b1111, 0, 0);
        send(16'hFFFF, 12, 0);

        // Reset mid-pattern with load and en asserted alongside.
        step(0, 1, 4'b1011, 0, 0);
        send(16'b10, 2, 0);
        step(1, 1, 4'b1011, 1, 1);
        send(16'b1011, 4, 0);

        // Randomized traffic; a small pattern alphabet keeps matches frequent.
        for (int k = 0; k < 800; k++) begin
            bit r, l;
            r = ($urandom_range(0, 149) == 0);
            l = ($urandom_range(0, 39) == 0);
            step(r, l, 4'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
